decoder_1_to_2: RTL and testbench

- 1-to-2 line decoder with active-high enable. Combinational one-hot output, plus a clocked snapshot of that output and per-line saturating activity counters for debug and observability.
- Used as the leaf select decoder in the mux/decoder component library and as the building block for wider decoders.

---
 rtl/decoder_pkg.sv | 16 +
 rtl/decoder_1_to_2_sat_counter.sv | 34 +++
 rtl/decoder_1_to_2.sv | 90 +++++++++
 tb/tb_decoder_1_to_2.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the 1-to-2 decoder slice.
package decoder_pkg;

  localparam int DEC_OUT_W = 2;

  typedef logic [DEC_OUT_W-1:0] dec2_t;

  localparam dec2_t DEC_NONE = 2'b00;
  localparam dec2_t DEC_BOTH = 2'b11;

  // An X on sel with ena high propagates through the shift as X on the output.
  function automatic dec2_t dec_decode(input logic ena, input logic sel);
    return ena ? (dec2_t'(1) << sel) : DEC_NONE;
  endfunction

endpackage

// File: rtl/decoder_1_to_2_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/decoder_1_to_2.sv
// 1-to-2 enable decoder with registered snapshot and per-line activity counters.
// Define DECODER_1_TO_2_ONEHOT_CHECK_EN to add the sticky err output and the one-hot assertion.
module decoder_1_to_2
  import decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in,
  input  logic                 ena,
  input  logic                 clr,
  output logic [DEC_OUT_W-1:0] out,
  output logic [DEC_OUT_W-1:0] out_q,
`ifdef DECODER_1_TO_2_ONEHOT_CHECK_EN
  output logic                 err,
`endif
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1
);

  dec2_t out_dec;
  dec2_t snap_q;
  dec2_t snap_d;

  assign out_dec = dec_decode(ena, in);
  assign out     = out_dec;

  always_comb begin
    snap_d = out_dec;
    if (clr) begin
      snap_d = DEC_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= DEC_NONE;
    end else begin
      snap_q <= snap_d;
    end
  end

  assign out_q = snap_q;

  sat_counter #(.W(CNT_W)) u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (out_dec[0]),
    .count (cnt0)
  );

  sat_counter #(.W(CNT_W)) u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (out_dec[1]),
    .count (cnt1)
  );

`ifdef DECODER_1_TO_2_ONEHOT_CHECK_EN
  logic err_q;
  logic err_d;

  always_comb begin
    err_d = err_q | (snap_q == DEC_BOTH);
    if (clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

  // Case equality so an X on in (legal while ena=1) does not trip the check.
  always_comb begin
    assert (!(out_dec === DEC_BOTH))
      else $error("decoder_1_to_2: out is 2'b11");
  end
`endif

endmodule

// File: tb/tb_decoder_1_to_2.sv
// Directed self-checking bench for decoder_1_to_2 (CNT_W=8 main instance, CNT_W=3 saturation instance).
module tb_decoder_1_to_2;

  logic       clk;
  logic       rst_n;
  logic       in;
  logic       ena;
  logic       clr;
  logic [1:0] out;
  logic [1:0] out_q;
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [1:0] out_s;
  logic [1:0] out_q_s;
  logic [2:0] cnt0_s;
  logic [2:0] cnt1_s;
`ifdef DECODER_1_TO_2_ONEHOT_CHECK_EN
  logic       err;
  logic       err_s;
`endif

  int n_checks = 0;
  int n_errors = 0;

  decoder_1_to_2 #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .ena   (ena),
    .clr   (clr),
    .out   (out),
    .out_q (out_q),
`ifdef DECODER_1_TO_2_ONEHOT_CHECK_EN
    .err   (err),
`endif
    .cnt0  (cnt0),
    .cnt1  (cnt1)
  );

  decoder_1_to_2 #(.CNT_W(3)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .ena   (ena),
    .clr   (clr),
    .out   (out_s),
    .out_q (out_q_s),
`ifdef DECODER_1_TO_2_ONEHOT_CHECK_EN
    .err   (err_s),
`endif
    .cnt0  (cnt0_s),
    .cnt1  (cnt1_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic i, input logic c);
    @(negedge clk);
    ena = e;
    in  = i;
    clr = c;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_out;

    rst_n = 1'b0;
    ena   = 1'b0;
    in    = 1'b0;
    clr   = 1'b0;
    #3;
    check("reset_out_q", 32'(out_q), 32'd0);
    check("reset_cnt0", 32'(cnt0), 32'd0);
    check("reset_cnt1", 32'(cnt1), 32'd0);

    // Combinational truth table, held in reset so the clocked state stays known.
    ena = 1'b0; in = 1'b0; #1; check("comb_e0_i0", 32'(out), 32'h0);
    ena = 1'b0; in = 1'b1; #1; check("comb_e0_i1", 32'(out), 32'h0);
    ena = 1'b1; in = 1'b0; #1; check("comb_e1_i0", 32'(out), 32'h1);
    ena = 1'b1; in = 1'b1; #1; check("comb_e1_i1", 32'(out), 32'h2);
    ena = 1'b0; in = 1'bx; #1; check("comb_e0_ix", 32'(out), 32'h0);

    for (int e = 0; e < 2; e++) begin
      for (int k = 0; k < 100; k++) begin
        ena = e[0];
        in  = 1'($urandom_range(0, 1));
        #1;
        exp_out = (ena == 1'b0) ? 2'b00 : ((in == 1'b1) ? 2'b10 : 2'b01);
        check("comb_rand", 32'(out), 32'(exp_out));
      end
    end

    // Latency and counting on line 1.
    drive(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    #1;
    check("lat_out_pre", 32'(out), 32'h2);
    check("lat_out_q_pre", 32'(out_q), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      edge_sample();
      check("lat_out_q", 32'(out_q), 32'h2);
      check("lat_cnt1", 32'(cnt1), 32'(k));
    end
    check("lat_cnt0", 32'(cnt0), 32'd0);

    // Asynchronous reset mid-cycle, away from any edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_q", 32'(out_q), 32'h0);
    check("arst_cnt1", 32'(cnt1), 32'd0);
    check("arst_out_tracks", 32'(out), 32'h2);
    in = 1'b0;
    #1;
    check("arst_out_tracks2", 32'(out), 32'h1);

    // Saturation on the 3-bit instance; 8-bit instance keeps counting.
    drive(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      edge_sample();
      check("sat_cnt0_s", 32'(cnt0_s), (k > 7) ? 32'd7 : 32'(k));
    end
    check("sat_cnt1_s", 32'(cnt1_s), 32'd0);
    check("wide_cnt0", 32'(cnt0), 32'd10);
    check("wide_out_q", 32'(out_q), 32'h1);

    // clr wins over counting on the same edge.
    drive(1'b1, 1'b0, 1'b1);
    edge_sample();
    check("clr_cnt0", 32'(cnt0), 32'd0);
    check("clr_out_q", 32'(out_q), 32'h0);
    check("clr_cnt0_s", 32'(cnt0_s), 32'd0);
    drive(1'b1, 1'b0, 1'b0);
    edge_sample();
    check("resume_cnt0", 32'(cnt0), 32'd1);
    check("resume_out_q", 32'(out_q), 32'h1);

    // Disabled: snapshot goes to zero, counters hold.
    drive(1'b0, 1'b1, 1'b0);
    edge_sample();
    check("dis_out_q", 32'(out_q), 32'h0);
    check("dis_cnt0", 32'(cnt0), 32'd1);
    check("dis_cnt1", 32'(cnt1), 32'd0);

    // Alternate lines: only one counter moves per edge.
    drive(1'b1, 1'b1, 1'b0);
    edge_sample();
    drive(1'b1, 1'b0, 1'b0);
    edge_sample();
    drive(1'b1, 1'b1, 1'b0);
    edge_sample();
    check("alt_cnt0", 32'(cnt0), 32'd2);
    check("alt_cnt1", 32'(cnt1), 32'd2);
    check("alt_out_q", 32'(out_q), 32'h2);

`ifdef DECODER_1_TO_2_ONEHOT_CHECK_EN
    for (int k = 0; k < 20; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      edge_sample();
      check("err_quiet", 32'(err), 32'd0);
    end
    @(negedge clk);
    force dut.snap_q = 2'b11;
    edge_sample();
    check("err_set", 32'(err), 32'd1);
    @(negedge clk);
    release dut.snap_q;
    edge_sample();
    check("err_sticky", 32'(err), 32'd1);
    drive(1'b0, 1'b0, 1'b1);
    edge_sample();
    check("err_clr", 32'(err), 32'd0);
    drive(1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
